// File: rtl/sop_eval_prog.sv
// Programmable sum-of-products evaluator: a 2-stage valid/ready pipeline with a drain-then-write term table.
// Define SOP_TERM_HIT_EN to add the term_hit output (per-term match vector aligned with f_out).
module sop_eval_prog #(
  parameter int N_IN   = 5,
  parameter int N_TERM = 6,
  localparam int IDX_W = (N_TERM > 1) ? $clog2(N_TERM) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [N_IN-1:0]   cfg_care,
  input  logic [N_IN-1:0]   cfg_val,
  input  logic              cfg_ten,
  output logic              cfg_ack,
  input  logic              in_valid,
  input  logic [N_IN-1:0]   in_vec,
  output logic              in_ready,
  output logic              out_valid,
  output logic              f_out,
  input  logic              out_ready,
  output logic [15:0]       eval_cnt
`ifdef SOP_TERM_HIT_EN
  ,
  output logic [N_TERM-1:0] term_hit
`endif
);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_CFG   = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [N_IN-1:0]   care_q [N_TERM];
  logic [N_IN-1:0]   care_d [N_TERM];
  logic [N_IN-1:0]   val_q  [N_TERM];
  logic [N_IN-1:0]   val_d  [N_TERM];
  logic [N_TERM-1:0] ten_q, ten_d;

  logic              vld_p1_q, vld_p1_d;
  logic [N_TERM-1:0] match_p1_q, match_p1_d;
  logic              vld_p2_q, vld_p2_d;
  logic              f_p2_q, f_p2_d;
  logic [N_TERM-1:0] hit_p2_q, hit_p2_d;
  logic [15:0]       eval_cnt_q, eval_cnt_d;

  logic              pipe_empty, adv_p1, adv_p2, in_fire, out_fire;
  logic [N_TERM-1:0] match_c;

  assign pipe_empty = !vld_p1_q && !vld_p2_q;
  assign adv_p2     = !vld_p2_q || out_ready;
  assign adv_p1     = !vld_p1_q || adv_p2;
  // A pending write blocks new inputs so the table swap sees an empty pipe.
  assign in_ready   = rst_n && (state_q == ST_RUN) && !cfg_we && adv_p1;
  assign in_fire    = in_valid && in_ready;
  assign out_fire   = vld_p2_q && out_ready;

  assign cfg_ack    = (state_q == ST_CFG);
  assign out_valid  = vld_p2_q;
  assign f_out      = f_p2_q;
  assign eval_cnt   = eval_cnt_q;
`ifdef SOP_TERM_HIT_EN
  assign term_hit   = hit_p2_q;
`endif

  always_comb begin
    for (int t = 0; t < N_TERM; t++) begin
      match_c[t] = ten_q[t] && (((in_vec ^ val_q[t]) & care_q[t]) == '0);
    end
  end

  always_comb begin
    state_d = state_q;
    care_d  = care_q;
    val_d   = val_q;
    ten_d   = ten_q;
    case (state_q)
      ST_RUN:   if (cfg_we) state_d = pipe_empty ? ST_CFG : ST_DRAIN;
      ST_DRAIN: if (pipe_empty) state_d = ST_CFG;
      ST_CFG: begin
        state_d = ST_RUN;
        if (32'(cfg_idx) < 32'(N_TERM)) begin
          care_d[cfg_idx] = cfg_care;
          val_d[cfg_idx]  = cfg_val;
          ten_d[cfg_idx]  = cfg_ten;
        end
      end
      default:  state_d = ST_RUN;
    endcase
  end

  always_comb begin
    vld_p1_d   = vld_p1_q;
    match_p1_d = match_p1_q;
    vld_p2_d   = vld_p2_q;
    f_p2_d     = f_p2_q;
    hit_p2_d   = hit_p2_q;
    eval_cnt_d = eval_cnt_q;
    // stage 1: capture the per-term match vector
    if (adv_p1) begin
      vld_p1_d = in_fire;
      if (in_fire) match_p1_d = match_c;
    end
    // stage 2: reduce to the SOP result
    if (adv_p2) begin
      vld_p2_d = vld_p1_q;
      if (vld_p1_q) begin
        f_p2_d   = |match_p1_q;
        hit_p2_d = match_p1_q;
      end
    end
    if (out_fire && (eval_cnt_q != 16'hFFFF)) eval_cnt_d = eval_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      ten_q      <= '0;
      for (int t = 0; t < N_TERM; t++) begin
        care_q[t] <= '0;
        val_q[t]  <= '0;
      end
      vld_p1_q   <= 1'b0;
      match_p1_q <= '0;
      vld_p2_q   <= 1'b0;
      f_p2_q     <= 1'b0;
      hit_p2_q   <= '0;
      eval_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      ten_q      <= ten_d;
      care_q     <= care_d;
      val_q      <= val_d;
      vld_p1_q   <= vld_p1_d;
      match_p1_q <= match_p1_d;
      vld_p2_q   <= vld_p2_d;
      f_p2_q     <= f_p2_d;
      hit_p2_q   <= hit_p2_d;
      eval_cnt_q <= eval_cnt_d;
    end
  end

endmodule

// File: tb/tb_sop_eval_prog.sv
// Scoreboard bench for sop_eval_prog: directed vectors push hand-computed results, a monitor pops on each output transfer.
module tb_sop_eval_prog;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cfg_we;
  logic [2:0] cfg_idx;
  logic [4:0] cfg_care, cfg_val;
  logic       cfg_ten, cfg_ack;
  logic       in_valid, in_ready;
  logic [4:0] in_vec;
  logic       out_valid, f_out, out_ready;
  logic [15:0] eval_cnt;
`ifdef SOP_TERM_HIT_EN
  logic [5:0] term_hit;
`endif

  sop_eval_prog #(.N_IN(5), .N_TERM(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_care(cfg_care), .cfg_val(cfg_val),
    .cfg_ten(cfg_ten), .cfg_ack(cfg_ack),
    .in_valid(in_valid), .in_vec(in_vec), .in_ready(in_ready),
    .out_valid(out_valid), .f_out(f_out), .out_ready(out_ready),
    .eval_cnt(eval_cnt)
`ifdef SOP_TERM_HIT_EN
    , .term_hit(term_hit)
`endif
  );

  always #5 clk = ~clk;

  int   chk_n = 0;
  int   pass_n = 0;
  int   cyc = 0;
  logic sb_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: every output transfer must match the oldest expected result.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        chk_n++;
        $display("FAIL unexpected_out: got f_out=%0b expected no transfer (t=%0t)", f_out, $time);
      end else begin
        chk("f_out", {31'd0, f_out}, {31'd0, sb_q.pop_front()});
      end
    end
  end

  task automatic send(input logic [4:0] v, input logic e);
    bit done = 0;
    in_valid = 1'b1;
    in_vec   = v;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        sb_q.push_back(e);
        done = 1;
      end
      @(posedge clk); #1;
    end
    if (!done) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic cfg_write(input logic [2:0] idx, input logic [4:0] care, input logic [4:0] val,
                           input logic ten, output int waits);
    bit done = 0;
    cfg_we = 1'b1; cfg_idx = idx; cfg_care = care; cfg_val = val; cfg_ten = ten;
    waits = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      chk("in_ready_during_cfg", {31'd0, in_ready}, 32'd0);
      if (cfg_ack) done = 1;
      else waits++;
      @(posedge clk); #1;
    end
    if (!done) chk("cfg_ack_timeout", 32'd0, 32'd1);
    cfg_we   = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 50 && sb_q.size() != 0; i++) @(negedge clk);
    chk("drain", sb_q.size(), 32'd0);
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
  endtask

  int w;
  int c0;
  int acc;
  logic [4:0] st_vec [3];
  logic       st_exp [3];

  initial begin
    rst_n = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_care = '0; cfg_val = '0; cfg_ten = 1'b0;
    in_valid = 1'b0; in_vec = '0; out_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_f_out", {31'd0, f_out}, 32'd0);
    chk("rst_cfg_ack", {31'd0, cfg_ack}, 32'd0);
    chk("rst_eval_cnt", {16'd0, eval_cnt}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready_after_rst", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;

    // Empty table gives 0, latency 2
    send(5'b10101, 1'b0);
    in_valid = 1'b0;
    @(negedge clk); chk("lat_cycle1", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk); chk("lat_cycle2", {31'd0, out_valid}, 32'd1);
    @(posedge clk); #1;
    @(negedge clk); chk("eval_cnt_1", {16'd0, eval_cnt}, 32'd1);
    @(posedge clk); #1;

    // Full-care term, back to back
    cfg_write(3'd0, 5'b11111, 5'b10101, 1'b1, w);
    chk("cfg_wait_empty", w, 32'd1);
    send(5'b10101, 1'b1);
    send(5'b10100, 1'b0);
    in_valid = 1'b0;
    wait_drain();
    // care=0 always matches; disabling it removes the match
    cfg_write(3'd1, 5'b00000, 5'b11111, 1'b1, w);
    send(5'b00000, 1'b1);
    in_valid = 1'b0;
    wait_drain();
    cfg_write(3'd1, 5'b00000, 5'b11111, 1'b0, w);
    send(5'b00000, 1'b0);
    in_valid = 1'b0;
    wait_drain();
    // Partial care: x x x 0 1
    cfg_write(3'd2, 5'b00011, 5'b00001, 1'b1, w);
    send(5'b11001, 1'b1);
    send(5'b11011, 1'b0);
    in_valid = 1'b0;
    wait_drain();
    chk("eval_cnt_7", {16'd0, eval_cnt}, 32'd7);

    // Stall: 3 offered over 5 cycles, only 2 accepted
    st_vec[0] = 5'b10101; st_exp[0] = 1'b1;
    st_vec[1] = 5'b00000; st_exp[1] = 1'b0;
    st_vec[2] = 5'b00001; st_exp[2] = 1'b1;
    out_ready = 1'b0;
    acc = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_vec = st_vec[acc];
      @(negedge clk);
      if (in_valid && in_ready) begin
        sb_q.push_back(st_exp[acc]);
        acc++;
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("stall_accepted", acc, 32'd2);
    chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
    chk("stall_f_hold", {31'd0, f_out}, 32'd1);
    chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_drain();
    chk("eval_cnt_9", {16'd0, eval_cnt}, 32'd9);

    // Cfg vs input collision with 2 in flight; in-flight results use old table
    send(5'b11001, 1'b1);
    send(5'b00000, 1'b0);
    in_vec = 5'b10101;
    cfg_write(3'd2, 5'b00011, 5'b00001, 1'b0, w);
    chk("drain_waits", w, 32'd3);
    wait_drain();
    send(5'b11001, 1'b0);
    send(5'b10101, 1'b1);
    in_valid = 1'b0;
    wait_drain();
    chk("eval_cnt_13", {16'd0, eval_cnt}, 32'd13);

    // Out-of-range index acked, table unchanged
    cfg_write(3'd7, 5'b11111, 5'b11001, 1'b1, w);
    chk("cfg_idx7_wait", w, 32'd1);
    send(5'b11001, 1'b0);
    send(5'b10101, 1'b1);
    in_valid = 1'b0;
    wait_drain();
    chk("eval_cnt_15", {16'd0, eval_cnt}, 32'd15);

    // Throughput and saturation
    c0 = cyc;
    for (int i = 0; i < 70000; i++) send(5'b10101, 1'b1);
    chk("throughput_cycles", cyc - c0, 32'd70000);
    in_valid = 1'b0;
    wait_drain();
    chk("eval_cnt_sat", {16'd0, eval_cnt}, 32'h0000FFFF);

    // Reset with full pipeline and pending write
    out_ready = 1'b0;
    send(5'b10101, 1'b1);
    send(5'b10101, 1'b1);
    in_valid = 1'b0;
    cfg_we = 1'b1; cfg_idx = 3'd0; cfg_care = 5'b00000; cfg_val = 5'b00000; cfg_ten = 1'b1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    sb_q.delete();
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("midrst_cfg_ack", {31'd0, cfg_ack}, 32'd0);
    chk("midrst_eval_cnt", {16'd0, eval_cnt}, 32'd0);
    cfg_we = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_no_out", {31'd0, out_valid}, 32'd0);
      chk("post_rst_no_ack", {31'd0, cfg_ack}, 32'd0);
      @(posedge clk); #1;
    end
    send(5'b10101, 1'b0);
    in_valid = 1'b0;
    wait_drain();
    chk("eval_cnt_post_rst", {16'd0, eval_cnt}, 32'd1);

    $display("%0d/%0d checks passed", pass_n, chk_n);
    $finish;
  end

endmodule

// File: doc/sop_eval_prog.md
SOP_EVAL_PROG -- requirements
Module: sop_eval_prog

Interface
REQ-001 The block SHALL have parameter N_IN, default 5, giving the number of Boolean input variables.
REQ-002 The block SHALL have parameter N_TERM, default 6, giving the number of programmable product terms.
REQ-003 Port clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 Port cfg_we  input  1  term-table write strobe.
REQ-006 Port cfg_idx  input  clog2(N_TERM)  index of the term being written.
REQ-007 Port cfg_care  input  N_IN  per-variable care mask (1 = variable appears in the term).
REQ-008 Port cfg_val  input  N_IN  required literal polarity per variable (1 = true, 0 = complemented).
REQ-009 Port cfg_ten  input  1  term enable written with the term.
REQ-010 Port cfg_ack  output  1  the write was accepted this cycle.
REQ-011 Port in_valid  input  1  in_vec is valid.
REQ-012 Port in_vec  input  N_IN  input variable vector.
REQ-013 Port in_ready  output  1  the block accepts in_vec this cycle.
REQ-014 Port out_valid  output  1  f_out is valid.
REQ-015 Port f_out  output  1  evaluated sum-of-products result.
REQ-016 Port out_ready  input  1  the consumer accepts f_out.
REQ-017 Port eval_cnt  output  16  count of results delivered.

Function
- REQ-018 Term t SHALL match when ten[t]=1 and ((in_vec ^ val[t]) & care[t]) == 0; a term with care=0 and ten=1 SHALL always match.
- REQ-019 f_out SHALL be the OR of all matches; no enabled term SHALL give f_out=0.
- REQ-020 Two-stage pipeline: stage 1 registers the N_TERM match vector; stage 2 registers the OR.
- REQ-021 Latency: an input accepted in cycle n SHALL produce out_valid in cycle n+2 when out_ready is held at 1.
- REQ-022 A transfer SHALL occur on either side only when valid and ready are both 1.
- REQ-023 Stall: when out_valid=1 and out_ready=0, f_out and stage 1 SHALL hold.
  - in_ready SHALL be 0 whenever stage 1 is full and cannot advance.
  - No result SHALL be dropped or duplicated.
- REQ-024 With out_ready=1 continuously, the block SHALL sustain one result per cycle.
- REQ-025 The controller FSM SHALL have three states:
  - RUN: normal evaluation.
  - DRAIN: a write is pending and the pipeline is non-empty; in_ready=0.
  - CFG: pipeline empty; the table write is performed, cfg_ack=1 for one cycle, then the FSM returns to RUN.
- REQ-026 cfg_we=1 in RUN SHALL move the FSM to DRAIN if the pipeline is non-empty, otherwise to CFG.
  - cfg_* SHALL be held by the source until cfg_ack.
- REQ-027 If cfg_we and in_valid are both 1 in the same cycle, the configuration SHALL win: in_ready=0 and the input is not accepted.
- REQ-028 A cfg_idx value >= N_TERM SHALL be acknowledged without modifying the table.
- REQ-029 The new table SHALL apply only to inputs accepted after cfg_ack; results already in flight SHALL use the old table.
- REQ-030 eval_cnt SHALL increment on each output transfer and SHALL saturate at 16'hFFFF.

Reset
- REQ-031 While rst_n=0, the following SHALL be cleared:
  - all term entries (ten=0, care=0, val=0) and both pipeline stages;
  - FSM to RUN;
  - out_valid=0, f_out=0, cfg_ack=0, eval_cnt=0.
- REQ-032 in_ready SHALL be 0 while rst_n=0 and 1 in the first cycle after deassertion.
- REQ-033 Reset mid-operation SHALL discard in-flight results and any pending write without producing a transfer or cfg_ack.

Configuration
- REQ-034 With macro SOP_TERM_HIT_EN defined, the block SHALL add output term_hit (N_TERM bits), registered in stage 2 and valid with out_valid.
  - term_hit SHALL hold under stall and SHALL reset to 0.
- REQ-035 Without SOP_TERM_HIT_EN, term_hit SHALL be absent, and all other behaviour SHALL be identical to the macro-defined build.

Verification
- REQ-036 After reset, send in_vec=5'b10101 -> out_valid 2 cycles later, f_out=0, eval_cnt=1.
- REQ-037 Write idx0 with care=5'b11111, val=5'b10101, ten=1, then send 5'b10101 and 5'b10100 back to back -> f_out=1 then 0 in consecutive cycles.
- REQ-038 Hold out_ready=0 for 5 cycles with 3 inputs offered -> only 2 are accepted, f_out holds, and after release 2 results arrive in order.
- REQ-039 Assert cfg_we and in_valid in the same cycle while 2 results are in flight -> DRAIN for 2 cycles, then cfg_ack; in-flight results use the old table.
- REQ-040 Write idx=7 (N_TERM=6) -> cfg_ack=1 and the table is unchanged; 70000 transfers -> eval_cnt=16'hFFFF.
- REQ-041 Pulse rst_n low with the pipeline full -> out_valid=0 immediately, with no stale result after release.
